// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared constants and helpers for the I/Q DAC packer
package iq_pkg;

  localparam int          IQ_BW_DEFAULT = 16;
  localparam logic [31:0] UNDERRUN_MAX  = 32'hFFFF_FFFF;

  function automatic int beat_w(input int bw, input int spb);
    return 2 * bw * spb;
  endfunction

endpackage

// File: rtl/iq_beat_fifo.sv
// rtl/iq_beat_fifo.sv - first-word-fall-through beat FIFO with level output
module iq_beat_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_pop      = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

endmodule

// File: rtl/iq_dac_packer.sv
// rtl/iq_dac_packer.sv - joins I/Q streams, packs samples into DAC beats, counts underruns
module iq_dac_packer
  import iq_pkg::*;
#(
  parameter int IQ_BW            = IQ_BW_DEFAULT,
  parameter int SAMPLES_PER_BEAT = 4,
  parameter int FIFO_DEPTH       = 8,
  localparam int BW = beat_w(IQ_BW, SAMPLES_PER_BEAT),
  localparam int CW = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             enable,
  input  logic             clear_stats,
  input  logic             i_in_TVALID,
  output logic             i_in_TREADY,
  input  logic [IQ_BW-1:0] i_in_TDATA,
  input  logic             q_in_TVALID,
  output logic             q_in_TREADY,
  input  logic [IQ_BW-1:0] q_in_TDATA,
  output logic             dac_out_TVALID,
  input  logic             dac_out_TREADY,
  output logic [BW-1:0]    dac_out_TDATA,
  output logic [LW-1:0]    fifo_level,
  output logic [31:0]      underrun_count
);

  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_pack;
  logic          r_primed;
  logic [31:0]   r_underrun_count;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_last;
  logic          w_pack_can_take;
  logic          w_accept_ok;
  logic          w_join;
  logic          w_push;
  logic          w_underrun;
  logic [BW-1:0] w_beat;

  assign dac_out_TVALID  = !w_empty;
  assign w_pop           = dac_out_TVALID && dac_out_TREADY;
  assign w_last          = (r_cnt == CW'(SAMPLES_PER_BEAT - 1));
  assign w_pack_can_take = !w_last || !w_full || w_pop;
  // Reset gating keeps READY low while reset is held, whatever the inputs do.
  assign w_accept_ok     = ap_rst_n && enable && w_pack_can_take;
  assign i_in_TREADY     = w_accept_ok && q_in_TVALID;
  assign q_in_TREADY     = w_accept_ok && i_in_TVALID;
  assign w_join          = w_accept_ok && i_in_TVALID && q_in_TVALID;
  assign w_push          = w_join && w_last;
  assign w_underrun      = r_primed && enable && dac_out_TREADY && !dac_out_TVALID;
  assign underrun_count  = r_underrun_count;

  always_comb begin
    w_beat = r_pack;
    w_beat[int'(r_cnt) * (2 * IQ_BW) +: 2 * IQ_BW] = {q_in_TDATA, i_in_TDATA};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
    end else if (w_join) begin
      r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
      r_pack <= w_beat;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_primed         <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      if (!enable)    r_primed <= 1'b0;
      else if (w_pop) r_primed <= 1'b1;
      if (clear_stats)
        r_underrun_count <= '0;
      else if (w_underrun && r_underrun_count != UNDERRUN_MAX)
        r_underrun_count <= r_underrun_count + 32'd1;
    end
  end

  iq_beat_fifo #(
    .WIDTH (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (ap_clk),
    .rst_n       (ap_rst_n),
    .i_push      (w_push),
    .i_push_data (w_beat),
    .i_pop       (w_pop),
    .o_pop_data  (dac_out_TDATA),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );

endmodule

// File: tb/tb_iq_dac_packer.sv
// tb/tb_iq_dac_packer.sv - directed self-checking bench for iq_dac_packer
module tb_iq_dac_packer;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n;
  logic         enable;
  logic         clear_stats;
  logic         i_in_TVALID;
  logic         i_in_TREADY;
  logic [15:0]  i_in_TDATA;
  logic         q_in_TVALID;
  logic         q_in_TREADY;
  logic [15:0]  q_in_TDATA;
  logic         dac_out_TVALID;
  logic         dac_out_TREADY;
  logic [127:0] dac_out_TDATA;
  logic [3:0]   fifo_level;
  logic [31:0]  underrun_count;

  int checks = 0;
  int errors = 0;
  int joins;

  always #5 ap_clk = ~ap_clk;

  iq_dac_packer #(
    .IQ_BW            (16),
    .SAMPLES_PER_BEAT (4),
    .FIFO_DEPTH       (8)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .enable         (enable),
    .clear_stats    (clear_stats),
    .i_in_TVALID    (i_in_TVALID),
    .i_in_TREADY    (i_in_TREADY),
    .i_in_TDATA     (i_in_TDATA),
    .q_in_TVALID    (q_in_TVALID),
    .q_in_TREADY    (q_in_TREADY),
    .q_in_TDATA     (q_in_TDATA),
    .dac_out_TVALID (dac_out_TVALID),
    .dac_out_TREADY (dac_out_TREADY),
    .dac_out_TDATA  (dac_out_TDATA),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic send(input logic [15:0] iv, input logic [15:0] qv);
    bit done = 0;
    i_in_TVALID = 1'b1;
    q_in_TVALID = 1'b1;
    i_in_TDATA  = iv;
    q_in_TDATA  = qv;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (i_in_TREADY && q_in_TREADY) done = 1;
      tick();
    end
    if (!done) chk("send_timeout", 128'(0), 128'(1));
    i_in_TVALID = 1'b0;
    q_in_TVALID = 1'b0;
  endtask

  function automatic logic [127:0] beat(input logic [15:0] ib, input logic [15:0] qb);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = {qb + 16'(k), ib + 16'(k)};
    return b;
  endfunction

  initial begin
    ap_rst_n       = 1'b0;
    enable         = 1'b1;
    clear_stats    = 1'b0;
    i_in_TVALID    = 1'b1;
    q_in_TVALID    = 1'b1;
    i_in_TDATA     = 16'h0;
    q_in_TDATA     = 16'h0;
    dac_out_TREADY = 1'b1;
    #12;
    chk("rst_i_ready", 128'(i_in_TREADY), 128'(0));
    chk("rst_q_ready", 128'(q_in_TREADY), 128'(0));
    chk("rst_valid", 128'(dac_out_TVALID), 128'(0));
    chk("rst_tdata", dac_out_TDATA, 128'(0));
    chk("rst_level", 128'(fifo_level), 128'(0));
    chk("rst_underrun", 128'(underrun_count), 128'(0));
    @(negedge ap_clk);
    i_in_TVALID = 1'b0;
    q_in_TVALID = 1'b0;
    ap_rst_n    = 1'b1;
    tick();

    // Ramp with DAC ready held high
    send(16'd1, 16'h0101);
    send(16'd2, 16'h0102);
    send(16'd3, 16'h0103);
    chk("ramp_valid_pre", 128'(dac_out_TVALID), 128'(0));
    send(16'd4, 16'h0104);
    chk("ramp_valid", 128'(dac_out_TVALID), 128'(1));
    chk("ramp_beat0", dac_out_TDATA, 128'h0104_0004_0103_0003_0102_0002_0101_0001);
    send(16'd5, 16'h0105);
    send(16'd6, 16'h0106);
    send(16'd7, 16'h0107);
    send(16'd8, 16'h0108);
    chk("ramp_beat1", dac_out_TDATA, 128'h0108_0008_0107_0007_0106_0006_0105_0005);
    tick();
    chk("ramp_drained", 128'(fifo_level), 128'(0));

    // Skewed valids: I arrives three cycles before Q
    i_in_TVALID = 1'b1;
    i_in_TDATA  = 16'h0011;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("skew_i_ready", 128'(i_in_TREADY), 128'(0));
      chk("skew_q_ready", 128'(q_in_TREADY), 128'(1));
      tick();
    end
    send(16'h0011, 16'h0021);
    send(16'h0012, 16'h0022);
    send(16'h0013, 16'h0023);
    send(16'h0014, 16'h0024);
    chk("skew_beat", dac_out_TDATA, beat(16'h0011, 16'h0021));
    tick();

    // Back-pressure: DAC stalled, stream offered continuously
    dac_out_TREADY = 1'b0;
    joins = 0;
    for (int n = 0; n < 40; n++) begin
      i_in_TVALID = 1'b1;
      q_in_TVALID = 1'b1;
      i_in_TDATA  = 16'(joins + 1);
      q_in_TDATA  = 16'h8000 + 16'(joins + 1);
      #1;
      if (i_in_TREADY) joins++;
      tick();
    end
    #1;
    chk("bp_joins", 128'(joins), 128'(35));
    chk("bp_level", 128'(fifo_level), 128'(8));
    chk("bp_ready_low", 128'(i_in_TREADY), 128'(0));
    i_in_TVALID    = 1'b0;
    q_in_TVALID    = 1'b0;
    dac_out_TREADY = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk("bp_drain_valid", 128'(dac_out_TVALID), 128'(1));
      chk("bp_drain_beat", dac_out_TDATA, beat(16'(4*b + 1), 16'h8000 + 16'(4*b + 1)));
      tick();
    end
    chk("bp_empty", 128'(fifo_level), 128'(0));

    // Enable drop mid-beat discards the partial pack only
    dac_out_TREADY = 1'b0;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int k = 0; k < 4; k++) send(16'h0031 + 16'(k), 16'h0041 + 16'(k));
    send(16'h0051, 16'h0061);
    send(16'h0052, 16'h0062);
    enable      = 1'b0;
    i_in_TVALID = 1'b1;
    q_in_TVALID = 1'b1;
    #1;
    chk("en_i_ready", 128'(i_in_TREADY), 128'(0));
    chk("en_q_ready", 128'(q_in_TREADY), 128'(0));
    chk("en_valid_held", 128'(dac_out_TVALID), 128'(1));
    tick();
    enable = 1'b1;
    for (int k = 0; k < 4; k++) send(16'h0071 + 16'(k), 16'h0081 + 16'(k));
    chk("en_level", 128'(fifo_level), 128'(2));
    dac_out_TREADY = 1'b1;
    #1;
    chk("en_beat_a", dac_out_TDATA, beat(16'h0031, 16'h0041));
    tick();
    chk("en_beat_c", dac_out_TDATA, beat(16'h0071, 16'h0081));
    tick();

    // Underrun counting, clear and saturation
    enable      = 1'b0;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("ur_cleared", 128'(underrun_count), 128'(0));
    enable = 1'b1;
    for (int k = 0; k < 4; k++) send(16'h0091 + 16'(k), 16'h00A1 + 16'(k));
    tick();
    for (int n = 0; n < 5; n++) tick();
    chk("ur_count5", 128'(underrun_count), 128'(5));
    force dut.r_underrun_count = 32'hFFFF_FFFD;
    #1;
    release dut.r_underrun_count;
    for (int n = 0; n < 4; n++) tick();
    chk("ur_saturate", 128'(underrun_count), 128'(32'hFFFF_FFFF));
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("ur_clear_prio", 128'(underrun_count), 128'(0));

    // Asynchronous reset with the FIFO half full
    dac_out_TREADY = 1'b0;
    for (int k = 0; k < 18; k++) send(16'h00B0 + 16'(k), 16'h00E0 + 16'(k));
    chk("ar_level_pre", 128'(fifo_level), 128'(4));
    i_in_TVALID = 1'b1;
    q_in_TVALID = 1'b1;
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(dac_out_TVALID), 128'(0));
    chk("ar_tdata", dac_out_TDATA, 128'(0));
    chk("ar_level", 128'(fifo_level), 128'(0));
    chk("ar_i_ready", 128'(i_in_TREADY), 128'(0));
    chk("ar_underrun", 128'(underrun_count), 128'(0));
    @(negedge ap_clk);
    ap_rst_n       = 1'b1;
    dac_out_TREADY = 1'b1;
    for (int k = 0; k < 4; k++) send(16'h00C1 + 16'(k), 16'h00D1 + 16'(k));
    chk("ar_new_beat", dac_out_TDATA, beat(16'h00C1, 16'h00D1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_dac_packer.md
# iq_dac_packer

Downstream neighbour of the modulator stage: joins the separate I and Q AXI-streams into one RF-DAC AXI-stream. Packs `SAMPLES_PER_BEAT` complex samples per output beat and buffers beats in a small FIFO to absorb DAC back-pressure. Reports DAC underruns through a saturating counter readable over AXI-lite.

## Interface
- `IQ_BW`, 16: bits per I or Q component.
- `SAMPLES_PER_BEAT`, 4: complex samples per output beat (1..8).
- `FIFO_DEPTH`, 8: output FIFO depth in beats (power of 2, ≥2).
- `ap_clk`  in  1  sole clock.
- `ap_rst_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  AXI-lite run control; low stops input acceptance.
- `clear_stats`  in  1  one-cycle pulse; clears `underrun_count`.
- `i_in_TVALID` / `i_in_TREADY` / `i_in_TDATA`  in / out / in  1/1/`IQ_BW`  I sample stream.
- `q_in_TVALID` / `q_in_TREADY` / `q_in_TDATA`  in / out / in  1/1/`IQ_BW`  Q sample stream.
- `dac_out_TVALID`  out  1  beat valid.
- `dac_out_TREADY`  in  1  DAC ready.
- `dac_out_TDATA`  out  `2*IQ_BW*SAMPLES_PER_BEAT`  packed beat.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  beats currently buffered.
- `underrun_count`  out  32  saturating DAC underrun count.

## Operation
- Join rules:
  - `accept_ok = enable && pack_can_take`.
  - `i_in_TREADY = accept_ok && q_in_TVALID`; `q_in_TREADY = accept_ok && i_in_TVALID`.
  - I and Q always transfer in the same cycle; neither transfers alone.
- Pack stage:
  - Counter `cnt` runs 0..SPB-1. Each join writes `{Q,I}` into slot `cnt`.
  - Slot k is `TDATA[k*2*IQ_BW +: 2*IQ_BW]`, with I in the low `IQ_BW` bits. Slot 0 is the earliest sample.
  - On the join at `cnt==SPB-1`, the completed beat is pushed to the FIFO and `cnt` wraps to 0.
- `pack_can_take` is 1 if `cnt<SPB-1`, or the FIFO is not full, or a pop occurs in the same cycle (full with simultaneous push and pop is legal).
- FIFO:
  - First-word-fall-through; `dac_out_TVALID = (level != 0)`; `dac_out_TDATA` is the head entry.
  - A pop happens on `TVALID && TREADY`.
  - Pointers wrap modulo `FIFO_DEPTH`. `fifo_level` tracks push−pop, and a simultaneous push and pop leaves it unchanged.
- Enable low:
  - Input READYs drop combinationally.
  - The partial pack is discarded (`cnt<=0`) on the next edge.
  - The FIFO keeps draining; a presented beat is never withdrawn.
- Underrun counting:
  - The `primed` flag sets on the first pop after `enable` rises, and clears when `enable` is low.
  - An underrun is a cycle with `primed && enable && dac_out_TREADY && !dac_out_TVALID`; `underrun_count` increments on each one.
  - The counter saturates at 0xFFFFFFFF.
  - `clear_stats` has priority over increment.
- Reset values: all TREADY/TVALID 0, `dac_out_TDATA` 0, `cnt` 0, FIFO empty, `fifo_level` 0, `primed` 0, `underrun_count` 0.
- Reset assertion mid-beat discards all buffered data immediately.

## Timing
- Latency: the join completing a beat at edge t gives `dac_out_TVALID=1` after edge t (visible in cycle t+1).
- Throughput: one join per cycle sustained while `dac_out_TREADY` stays high.
- With `dac_out_TREADY` low:
  - After `FIFO_DEPTH*SPB + SPB-1` joins, the input READYs fall.
  - Exactly one more join is allowed per pop.
- Enable high→low: no joins in that cycle; `cnt`=0 after the next edge.
- `underrun_count` updates one edge after the qualifying cycle.
- No combinational path from `dac_out_TREADY` to `dac_out_TVALID`/`TDATA`. The path `dac_out_TREADY`→input READY is permitted.

## Structure
- Shared package `iq_pkg`: `IQ_BW` default, beat-width function `beat_w(bw,spb)`, `UNDERRUN_MAX` constant.
- Sub-module `iq_beat_fifo`: synchronous FWFT FIFO, parameters width/depth, ports push/pop/full/empty/level.
- Join, pack and stats logic live in the top.

## Test plan
- Ramp in, READY held high: I=1..8, Q=0x101..0x108, SPB=4 → beat0 = {Q4,I4,…,Q1,I1} = 0x0104_0004_0103_0003_0102_0002_0101_0001. Beat1 contains samples 5..8. TVALID first rises one cycle after the 4th join.
- Skewed valids: I valid 3 cycles before Q → no transfer on either stream until both are valid; pairs stay aligned.
- Back-pressure: DAC READY low, stream continuously → READYs fall after 35 joins and `fifo_level`=8. Releasing READY drains 8 beats intact and in order.
- Enable drop after 2 samples of a beat → partial pack discarded. After re-enable, the next beat starts at the 1st new sample; buffered beats are still delivered.
- Underrun: prime, stall the inputs 5 cycles with DAC READY high → `underrun_count`=5. `clear_stats` gives 0. A forced value near 0xFFFFFFFF stays at 0xFFFFFFFF.
- Async reset asserted with FIFO half full → all outputs 0 immediately; first beat after release contains only new samples.
